// File: rtl/rx_rb_pkg.sv
// Shared types and constants for the receive packet-store controller.
package rx_rb_pkg;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_CRC} wr_state_e;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

    localparam logic [2:0]  RX_DATA_STATE = 3'b011;
    localparam logic [15:0] DROP_CNT_MAX  = 16'hFFFF;
endpackage

// File: rtl/rx_packet_rb_ctrl_if.sv
// Downstream byte-stream handshake: valid/ready plus packet framing flags.
interface rx_packet_rb_ctrl_if #(parameter int LEN_W = 16);
    logic             ovalid;
    logic             iready;
    logic             ofirst;
    logic             olast;
    logic [LEN_W-1:0] olen;

    modport master (output ovalid, ofirst, olast, olen, input iready);
    modport slave  (input ovalid, ofirst, olast, olen, output iready);
endinterface

// File: rtl/rx_packet_rb_ctrl_rb_read_seq.sv
// Read side: pops a committed length, then streams that many bytes from the round buffer.
module rb_read_seq
    import rx_rb_pkg::*;
#(
    parameter int pRB_WIDHT  = 14,
    parameter int pFIFO_SIZE = 16
) (
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  iLEN_empty,
    input  logic [pFIFO_SIZE-1:0] iLEN_rdata,
    output logic                  oLEN_rd_en,
    output logic [pRB_WIDHT-1:0]  oRB_raddr,
    rx_packet_rb_ctrl_if.master   strm
);
    rd_state_e             state_q, state_d;
    logic [pRB_WIDHT-1:0]  rptr_q, rptr_d;
    logic [pFIFO_SIZE-1:0] remain_q, remain_d;
    logic [pFIFO_SIZE-1:0] len_q, len_d;
    logic                  pop_c;

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= R_IDLE;
            rptr_q   <= '0;
            remain_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rptr_q   <= rptr_d;
            remain_q <= remain_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rptr_d   = rptr_q;
        remain_d = remain_q;
        len_d    = len_q;
        pop_c    = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!iLEN_empty) begin
                    len_d    = iLEN_rdata;
                    remain_d = iLEN_rdata;
                    pop_c    = 1'b1;
                    state_d  = R_STREAM;
                end
            end
            R_STREAM: begin
                if (strm.iready) begin
                    rptr_d   = rptr_q + pRB_WIDHT'(1);
                    remain_d = remain_q - pFIFO_SIZE'(1);
                    if (remain_q == pFIFO_SIZE'(1)) state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Pop is combinational on FIFO state; keep it quiet while reset is held.
    assign oLEN_rd_en  = pop_c & i_rst;
    assign oRB_raddr   = rptr_q;
    assign strm.ovalid = (state_q == R_STREAM);
    assign strm.ofirst = strm.ovalid && (remain_q == len_q);
    assign strm.olast  = strm.ovalid && (remain_q == pFIFO_SIZE'(1));
    assign strm.olen   = len_q;
endmodule

// File: rtl/rx_packet_rb_ctrl.sv
// Receive packet store controller: writes rx bytes into the round buffer, commits or
// rolls back on CRC result, and hands committed packets to the read sequencer.
module rx_packet_rb_ctrl
    import rx_rb_pkg::*;
#(
    parameter int         pRB_WIDHT      = 14,
    parameter int         pFIFO_SIZE     = 16,
    parameter int         pCRC_TIMEOUT   = 64,
    parameter logic [2:0] pRX_DATA_STATE = RX_DATA_STATE
) (
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  idv,
    input  logic [2:0]            iFSM_state,
    input  logic                  icrc_valid,
    input  logic                  icrc_ok,
    output logic                  oRB_wr_en,
    output logic [pRB_WIDHT-1:0]  oRB_waddr,
    output logic [pRB_WIDHT-1:0]  oRB_raddr,
    output logic                  oLEN_wr_en,
    output logic [pFIFO_SIZE-1:0] oLEN_wdata,
    output logic                  oLEN_rd_en,
    input  logic                  iLEN_empty,
    input  logic                  iLEN_full,
    input  logic [pFIFO_SIZE-1:0] iLEN_rdata,
    rx_packet_rb_ctrl_if.master   strm,
    output logic [15:0]           odrop_cnt,
    output logic                  obusy
);
    localparam int                    TO_W    = $clog2(pCRC_TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(pCRC_TIMEOUT - 1);
    localparam logic [pFIFO_SIZE-1:0] LEN_MAX = '1;

    wr_state_e             wstate_q, wstate_d;
    logic [pRB_WIDHT-1:0]  wptr_q, wptr_d, commit_q, commit_d;
    logic [pFIFO_SIZE-1:0] len_q, len_d;
    logic                  drop_q, drop_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  wr_en_c, push_c, crc_done_c, rx_byte, full;
    logic [pRB_WIDHT-1:0]  used;

    assign rx_byte = idv && (iFSM_state == pRX_DATA_STATE);
    // One slot stays empty so full and empty never alias.
    assign used    = wptr_q - oRB_raddr;
    assign full    = &used;

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            wstate_q   <= W_IDLE;
            wptr_q     <= '0;
            commit_q   <= '0;
            len_q      <= '0;
            drop_q     <= 1'b0;
            to_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            wptr_q     <= wptr_d;
            commit_q   <= commit_d;
            len_q      <= len_d;
            drop_q     <= drop_d;
            to_q       <= to_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        wstate_d   = wstate_q;
        wptr_d     = wptr_q;
        commit_d   = commit_q;
        len_d      = len_q;
        drop_d     = drop_q;
        to_d       = to_q;
        drop_cnt_d = drop_cnt_q;
        wr_en_c    = 1'b0;
        push_c     = 1'b0;
        crc_done_c = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (rx_byte) begin
                    if (full) begin
                        drop_d = 1'b1;
                    end else begin
                        wr_en_c = 1'b1;
                        wptr_d  = wptr_q + pRB_WIDHT'(1);
                    end
                    len_d    = pFIFO_SIZE'(1);
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (rx_byte) begin
                    if (full || drop_q) begin
                        drop_d = 1'b1;
                    end else begin
                        wr_en_c = 1'b1;
                        wptr_d  = wptr_q + pRB_WIDHT'(1);
                    end
                    if (len_q == LEN_MAX) drop_d = 1'b1;
                    else                  len_d  = len_q + pFIFO_SIZE'(1);
                end else begin
                    to_d     = '0;
                    wstate_d = W_CRC;
                end
            end
            W_CRC: begin
                to_d = to_q + TO_W'(1);
                if (icrc_valid && icrc_ok && !drop_q && !iLEN_full) begin
                    push_c     = 1'b1;
                    commit_d   = wptr_q;
                    crc_done_c = 1'b1;
                end else if (icrc_valid || (to_q == TO_LAST)) begin
                    // Rollback only rewinds to the last commit, which never passes the reader.
                    wptr_d     = commit_q;
                    crc_done_c = 1'b1;
                    if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
                end
                if (crc_done_c) begin
                    wstate_d = W_IDLE;
                    drop_d   = 1'b0;
                    len_d    = '0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign oRB_wr_en  = wr_en_c & i_rst;
    assign oRB_waddr  = wptr_q;
    assign oLEN_wr_en = push_c;
    assign oLEN_wdata = len_q;
    assign odrop_cnt  = drop_cnt_q;
    assign obusy      = (wstate_q != W_IDLE);

    rb_read_seq #(.pRB_WIDHT(pRB_WIDHT), .pFIFO_SIZE(pFIFO_SIZE)) u_read (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .iLEN_empty (iLEN_empty),
        .iLEN_rdata (iLEN_rdata),
        .oLEN_rd_en (oLEN_rd_en),
        .oRB_raddr  (oRB_raddr),
        .strm       (strm)
    );
endmodule
